// File: rtl/vga_scan_gen_pkg.sv
// rtl/vga_scan_gen_pkg.sv - 640x480@60 raster timing constants and pixel-stage record
package vga_timing_pkg;

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Boot position that centres the 128x128 logo on screen.
  localparam logic [9:0] ORG_C_RST = 10'd256;
  localparam logic [8:0] ORG_R_RST = 9'd176;

  typedef struct packed {
    logic [9:0]  col;
    logic [8:0]  row;
    logic        display_en;
    logic        sprite_hit;
    logic [13:0] rom_addr;
    logic        frame_start;
  } pix_t;

endpackage

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan generator outputs and sprite origin inputs
interface vga_scan_gen_if;

  logic [9:0]  sprite_c;
  logic [8:0]  sprite_r;
  logic [9:0]  col;
  logic [8:0]  row;
  logic        display_en;
  logic        sprite_hit;
  logic [13:0] rom_addr;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic        hsync;
  logic        vsync;

  modport master (
    input  sprite_c, sprite_r,
    output col, row, display_en, sprite_hit, rom_addr, frame_start, frame_count, hsync, vsync
  );

  modport slave (
    output sprite_c, sprite_r,
    input  col, row, display_en, sprite_hit, rom_addr, frame_start, frame_count, hsync, vsync
  );

endinterface

// File: rtl/vga_scan_gen_sync_delay_line.sv
// rtl/vga_scan_gen_sync_delay_line.sv - DEPTH-stage shift register, resets to all ones
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d    = shreg_q;
    shreg_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      shreg_d[i] = shreg_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '1;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q = shreg_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - 640x480 raster counters, sprite hit/ROM address, aligned syncs
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int SPRITE_W   = 128,
  parameter int SPRITE_H   = 128,
  parameter int PIPE_DELAY = 2
) (
  input  logic          vga_clk,
  input  logic          rst,
  vga_scan_gen_if.master scan
);

  localparam int         AW = $clog2(SPRITE_W);
  localparam int         AH = $clog2(SPRITE_H);
  localparam logic [10:0] SW = 11'(SPRITE_W);
  localparam logic [10:0] SH = 11'(SPRITE_H);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  org_c_q, org_c_d;
  logic [8:0]  org_r_q, org_r_d;
  logic [7:0]  frame_count_q, frame_count_d;
  pix_t        pix_q, pix_d;
  logic [10:0] dx, dy;
  logic        visible, hs_raw, vs_raw;
  logic [1:0]  sync_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    org_c_d = org_c_q;
    org_r_d = org_r_q;
    if (h_cnt_q == H_TOTAL - 10'd1) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_TOTAL - 10'd1) begin
        v_cnt_d = '0;
        // Origin only moves between frames so a frame never shows two positions.
        org_c_d = scan.sprite_c;
        org_r_d = scan.sprite_r;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end

    visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    dx      = {1'b0, h_cnt_q} - {1'b0, org_c_q};
    dy      = {1'b0, v_cnt_q} - {2'b00, org_r_q};

    pix_d            = '0;
    pix_d.display_en = visible;
    if (visible) begin
      pix_d.col = h_cnt_q;
      pix_d.row = v_cnt_q[8:0];
    end
    pix_d.sprite_hit = visible && (h_cnt_q >= org_c_q) && (dx < SW) &&
                       (v_cnt_q >= {1'b0, org_r_q}) && (dy < SH);
    // Power-of-two sprite: dy*SPRITE_W + dx is just the bit concatenation.
    if (pix_d.sprite_hit) begin
      pix_d.rom_addr = 14'({dy[AH-1:0], dx[AW-1:0]});
    end
    pix_d.frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    frame_count_d = frame_count_q + (pix_q.frame_start ? 8'd1 : 8'd0);

    hs_raw = !((h_cnt_q >= H_VIS + H_FP) && (h_cnt_q < H_VIS + H_FP + H_SYNC));
    vs_raw = !((v_cnt_q >= V_VIS + V_FP) && (v_cnt_q < V_VIS + V_FP + V_SYNC));
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      org_c_q       <= ORG_C_RST;
      org_r_q       <= ORG_R_RST;
      pix_q         <= '0;
      frame_count_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      org_c_q       <= org_c_d;
      org_r_q       <= org_r_d;
      pix_q         <= pix_d;
      frame_count_q <= frame_count_d;
    end
  end

  // One stage matching the pixel register plus the downstream ROM/pixel latency.
  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (1 + PIPE_DELAY)
  ) u_sync_delay (
    .clk (vga_clk),
    .rst (rst),
    .d   ({hs_raw, vs_raw}),
    .q   (sync_q)
  );

  assign scan.col         = pix_q.col;
  assign scan.row         = pix_q.row;
  assign scan.display_en  = pix_q.display_en;
  assign scan.sprite_hit  = pix_q.sprite_hit;
  assign scan.rom_addr    = pix_q.rom_addr;
  assign scan.frame_start = pix_q.frame_start;
  assign scan.frame_count = frame_count_q;
  assign scan.hsync       = sync_q[1];
  assign scan.vsync       = sync_q[0];

endmodule
